// File: rtl/zx_flash_pkg.sv
// Shared types and constants for the ZX flash/SRAM access port.
// Used by zx_flash_seq and zx_flash_port.
package zx_flash_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } seq_state_t;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_type_t;

  localparam logic [7:0] DEF_ADDR_PORT = 8'hB3;
  localparam logic [7:0] DEF_DATA_PORT = 8'hBB;

  // Strobe timer width; covers WAIT_CYC up to 15.
  localparam int WAIT_CNT_W = 4;

  function automatic int phases_for(input int aw);
    return (aw + 7) / 8;
  endfunction

endpackage

// File: rtl/zx_flash_seq.sv
// Memory cycle sequencer: turns one accepted request into a SETUP/STROBE/HOLD
// cycle with registered chip strobes and a read-data latch pulse.
//
// state  | meaning
// IDLE   | no cycle; accepts req_valid
// SETUP  | mem_cs high, address/data presented, strobes low
// STROBE | mem_oe or mem_we high for WAIT_CYC clocks (down-counter)
// HOLD   | strobes low, mem_cs still high, address/data held
module zx_flash_seq
  import zx_flash_pkg::*;
#(
  parameter int AW       = 19,
  parameter int WAIT_CYC = 4
) (
  input  logic          clk_fpga,
  input  logic          rst,
  input  logic          abort,
  input  logic          req_valid,
  input  req_type_t     req_type,
  input  logic [AW-1:0] req_addr,
  input  logic [7:0]    req_data,
  output logic [AW-1:0] mem_a,
  output logic [7:0]    mem_dout,
  output logic          mem_cs,
  output logic          mem_oe,
  output logic          mem_we,
  output logic          mem_drv,
  output logic          busy,
  output logic          rd_latch
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYC - 1);

  seq_state_t              state;
  req_type_t               cur_type;
  logic [WAIT_CNT_W-1:0]   wait_cnt;

  // High during the last STROBE clock of a read; the port samples mem_din on its edge.
  assign rd_latch = (state == STROBE) && (wait_cnt == '0) && (cur_type == REQ_RD);

  always_ff @(posedge clk_fpga or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur_type <= REQ_RD;
      wait_cnt <= '0;
      mem_a    <= '0;
      mem_dout <= '0;
      mem_cs   <= 1'b0;
      mem_oe   <= 1'b0;
      mem_we   <= 1'b0;
      mem_drv  <= 1'b0;
      busy     <= 1'b0;
    end else if (abort) begin
      state    <= IDLE;
      wait_cnt <= '0;
      mem_cs   <= 1'b0;
      mem_oe   <= 1'b0;
      mem_we   <= 1'b0;
      mem_drv  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state    <= SETUP;
            cur_type <= req_type;
            mem_a    <= req_addr;
            mem_dout <= req_data;
            mem_cs   <= 1'b1;
            mem_drv  <= (req_type == REQ_WR);
            busy     <= 1'b1;
          end
        end
        SETUP: begin
          state    <= STROBE;
          wait_cnt <= WAIT_LOAD;
          mem_oe   <= (cur_type == REQ_RD);
          mem_we   <= (cur_type == REQ_WR);
        end
        STROBE: begin
          if (wait_cnt == '0) begin
            state  <= HOLD;
            mem_oe <= 1'b0;
            mem_we <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        HOLD: begin
          state   <= IDLE;
          mem_cs  <= 1'b0;
          mem_drv <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/zx_flash_port.sv
// ZX IO-mapped window onto an external parallel memory: phased address load,
// auto-incrementing data port with one-read-lag prefetch. Optional macro
// FLASH_PORT_PEND_EN adds a one-deep buffer for requests arriving while busy.
module zx_flash_port
  import zx_flash_pkg::*;
#(
  parameter int         AW        = 19,
  parameter int         NPH       = 3,
  parameter int         WAIT_CYC  = 4,
  parameter logic [7:0] ADDR_PORT = DEF_ADDR_PORT,
  parameter logic [7:0] DATA_PORT = DEF_DATA_PORT
) (
  input  logic          clk_fpga,
  input  logic          rst,
  input  logic          init,
  input  logic          io_wr_stb,
  input  logic          io_rd_stb,
  input  logic [7:0]    io_addr,
  input  logic [7:0]    io_wdata,
  output logic [7:0]    io_rdata,
  output logic [AW-1:0] mem_a,
  output logic [7:0]    mem_dout,
  input  logic [7:0]    mem_din,
  output logic          mem_cs,
  output logic          mem_oe,
  output logic          mem_we,
  output logic          mem_drv,
  output logic          busy,
  output logic          ovf
);

  localparam int             PHW     = (NPH > 1) ? $clog2(NPH) : 1;
  localparam logic [PHW-1:0] PH_LAST = PHW'(NPH - 1);

  logic [AW-1:0]    addr;
  logic [PHW-1:0]   ph;
  logic [7:0]       prefetch;
  logic [8*NPH-1:0] addr_ext;

  logic             addr_wr;
  logic             data_wr;
  logic             data_rd;
  logic             data_acc;
  logic             lost;
  req_type_t        live_type;
  logic [7:0]       live_data;

  logic             seq_req_valid;
  req_type_t        seq_req_type;
  logic [AW-1:0]    seq_req_addr;
  logic [7:0]       seq_req_data;
  logic             rd_latch;

  // init masks the strobes so a colliding access is simply dropped.
  assign addr_wr   = io_wr_stb && (io_addr == ADDR_PORT) && !init;
  assign data_wr   = io_wr_stb && (io_addr == DATA_PORT) && !init;
  assign data_rd   = io_rd_stb && !io_wr_stb && (io_addr == DATA_PORT) && !init;
  assign data_acc  = data_wr || data_rd;
  assign live_type = data_wr ? REQ_WR : REQ_RD;
  assign live_data = data_wr ? io_wdata : 8'h00;
  assign io_rdata  = prefetch;

  always_comb begin
    addr_ext             = '0;
    addr_ext[AW-1:0]     = addr;
    addr_ext[8*ph +: 8]  = io_wdata;
  end

`ifdef FLASH_PORT_PEND_EN
  logic          pend_valid;
  req_type_t     pend_type;
  logic [AW-1:0] pend_addr;
  logic [7:0]    pend_data;

  // A held request goes first; a new access in that same idle cycle takes its slot.
  assign seq_req_valid = !init && !busy && (pend_valid || data_acc);
  assign seq_req_type  = pend_valid ? pend_type : live_type;
  assign seq_req_addr  = pend_valid ? pend_addr : addr;
  assign seq_req_data  = pend_valid ? pend_data : live_data;
  assign lost          = data_acc && busy && pend_valid;

  always_ff @(posedge clk_fpga or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_type  <= REQ_RD;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else if (init) begin
      pend_valid <= 1'b0;
    end else if (!busy) begin
      pend_valid <= pend_valid && data_acc;
      if (data_acc) begin
        pend_type <= live_type;
        pend_addr <= addr;
        pend_data <= live_data;
      end
    end else if (data_acc && !pend_valid) begin
      pend_valid <= 1'b1;
      pend_type  <= live_type;
      pend_addr  <= addr;
      pend_data  <= live_data;
    end
  end
`else
  assign seq_req_valid = data_acc && !busy;
  assign seq_req_type  = live_type;
  assign seq_req_addr  = addr;
  assign seq_req_data  = live_data;
  assign lost          = data_acc && busy;
`endif

  // addr advances even on dropped accesses so it tracks the host's own count.
  always_ff @(posedge clk_fpga or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      ph       <= '0;
      prefetch <= '0;
      ovf      <= 1'b0;
    end else if (init) begin
      addr     <= '0;
      ph       <= '0;
      prefetch <= '0;
      ovf      <= 1'b0;
    end else begin
      if (addr_wr) begin
        addr <= addr_ext[AW-1:0];
        ph   <= (ph == PH_LAST) ? '0 : ph + 1'b1;
      end else if (data_acc) begin
        addr <= addr + 1'b1;
        ph   <= '0;
      end
      if (rd_latch) begin
        prefetch <= mem_din;
      end
      if (lost) begin
        ovf <= 1'b1;
      end
    end
  end

  zx_flash_seq #(
    .AW       (AW),
    .WAIT_CYC (WAIT_CYC)
  ) u_seq (
    .clk_fpga  (clk_fpga),
    .rst       (rst),
    .abort     (init),
    .req_valid (seq_req_valid),
    .req_type  (seq_req_type),
    .req_addr  (seq_req_addr),
    .req_data  (seq_req_data),
    .mem_a     (mem_a),
    .mem_dout  (mem_dout),
    .mem_cs    (mem_cs),
    .mem_oe    (mem_oe),
    .mem_we    (mem_we),
    .mem_drv   (mem_drv),
    .busy      (busy),
    .rd_latch  (rd_latch)
  );

endmodule

// File: tb/tb_zx_flash_port.sv
// Directed bench for zx_flash_port: memory cycles are captured by a monitor
// and matched against expectations queued when each IO access is driven.
module tb_zx_flash_port;

  localparam int AW = 19;
  localparam int WC = 4;

  typedef struct packed {
    logic          is_wr;
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic [3:0]    slen;
    logic [3:0]    cs_len;
    logic [3:0]    drv_len;
    logic          stable;
  } cyc_t;

  logic          clk_fpga = 1'b0;
  logic          rst;
  logic          init;
  logic          io_wr_stb;
  logic          io_rd_stb;
  logic [7:0]    io_addr;
  logic [7:0]    io_wdata;
  logic [7:0]    io_rdata;
  logic [AW-1:0] mem_a;
  logic [7:0]    mem_dout;
  logic [7:0]    mem_din;
  logic          mem_cs;
  logic          mem_oe;
  logic          mem_we;
  logic          mem_drv;
  logic          busy;
  logic          ovf;

  logic [7:0]    mem_model [1024];
  cyc_t          exp_q[$];
  cyc_t          obs_q[$];
  int            vectors = 0;
  int            miscompares = 0;

  zx_flash_port dut (
    .clk_fpga  (clk_fpga),
    .rst       (rst),
    .init      (init),
    .io_wr_stb (io_wr_stb),
    .io_rd_stb (io_rd_stb),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .mem_a     (mem_a),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .mem_cs    (mem_cs),
    .mem_oe    (mem_oe),
    .mem_we    (mem_we),
    .mem_drv   (mem_drv),
    .busy      (busy),
    .ovf       (ovf)
  );

  initial forever #5 clk_fpga = ~clk_fpga;

  assign mem_din = mem_oe ? mem_model[mem_a[9:0]] : 8'h00;

  // Monitor: one record per mem_cs window.
  initial begin
    cyc_t cur;
    logic in_cyc;
    in_cyc = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk_fpga);
      if (mem_cs) begin
        if (!in_cyc) begin
          in_cyc = 1'b1;
          cur = '0;
          cur.a = mem_a;
          cur.d = mem_dout;
          cur.stable = 1'b1;
        end
        if (mem_a != cur.a || mem_dout != cur.d) cur.stable = 1'b0;
        if (mem_we) cur.is_wr = 1'b1;
        if (mem_we || mem_oe) cur.slen = cur.slen + 4'd1;
        if (mem_drv) cur.drv_len = cur.drv_len + 4'd1;
        cur.cs_len = cur.cs_len + 4'd1;
      end else if (in_cyc) begin
        in_cyc = 1'b0;
        if (!cur.is_wr) cur.d = 8'h00;
        obs_q.push_back(cur);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic cyc_t mk_exp(input logic is_wr, input logic [AW-1:0] a, input logic [7:0] d);
    cyc_t c;
    c.is_wr   = is_wr;
    c.a       = a;
    c.d       = is_wr ? d : 8'h00;
    c.slen    = 4'(WC);
    c.cs_len  = 4'(WC + 2);
    c.drv_len = is_wr ? 4'(WC + 2) : 4'd0;
    c.stable  = 1'b1;
    return c;
  endfunction

  task automatic tick;
    @(posedge clk_fpga);
    #1;
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    io_addr   = a;
    io_wdata  = d;
    io_wr_stb = 1'b1;
    tick();
    io_wr_stb = 1'b0;
  endtask

  task automatic io_read(input logic [7:0] a, output logic [7:0] d);
    io_addr   = a;
    io_rd_stb = 1'b1;
    d         = io_rdata;
    tick();
    io_rd_stb = 1'b0;
  endtask

  task automatic init_pulse;
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic wait_idle;
    int idle_run;
    idle_run = 0;
    for (int i = 0; i < 200 && idle_run < 3; i++) begin
      tick();
      if (!busy) idle_run++;
      else idle_run = 0;
    end
    if (idle_run < 3) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: busy=%b after 200 cycles, required 0", busy);
    end
  endtask

  task automatic test_reset;
    logic [AW+22:0] outs;
    rst = 1'b1;
    repeat (3) tick();
    outs = {io_rdata, mem_a, mem_dout, mem_cs, mem_oe, mem_we, mem_drv, busy, ovf};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    rst = 1'b0;
    io_write(8'hB3, 8'h77);
    vectors++;
    if (dut.addr !== 19'h00077 || dut.ph !== 2'd1) begin
      miscompares++;
      $display("FAIL first_cycle_accept: addr=%h ph=%0d, required 00077 ph=1", dut.addr, dut.ph);
    end
    init_pulse();
    vectors++;
    if (dut.addr !== 19'h0 || dut.ph !== 2'd0) begin
      miscompares++;
      $display("FAIL init_clear: addr=%h ph=%0d, required 0 ph=0", dut.addr, dut.ph);
    end
  endtask

  task automatic test_addr_load;
    cyc_t e, o;
    logic [7:0] rd;
    io_write(8'hB3, 8'h12);
    io_write(8'hB3, 8'h34);
    io_write(8'hB3, 8'h05);
    vectors++;
    if (dut.addr !== 19'h53412 || dut.ph !== 2'd0) begin
      miscompares++;
      $display("FAIL addr_load3: addr=%h ph=%0d, required 53412 ph=0", dut.addr, dut.ph);
    end
    io_write(8'hB3, 8'hAA);
    vectors++;
    if (dut.addr !== 19'h534AA || dut.ph !== 2'd1) begin
      miscompares++;
      $display("FAIL addr_load4: addr=%h ph=%0d, required 534aa ph=1", dut.addr, dut.ph);
    end
    io_write(8'h55, 8'hEE);
    io_read(8'h55, rd);
    tick();
    vectors++;
    if (dut.addr !== 19'h534AA || dut.ph !== 2'd1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL other_port: addr=%h ph=%0d busy=%b, required 534aa ph=1 busy=0", dut.addr, dut.ph, busy);
    end
    exp_q.push_back(mk_exp(1'b1, 19'h534AA, 8'h3C));
    io_write(8'hBB, 8'h3C);
    wait_idle();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL addr_load_cycle: no cycle seen, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL addr_load_cycle: got %h, required %h", o, e);
        end
      end
    end
    vectors++;
    if (dut.addr !== 19'h534AB || dut.ph !== 2'd0 || obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL addr_after_data: addr=%h ph=%0d extra=%0d, required 534ab ph=0 extra=0", dut.addr, dut.ph, obs_q.size());
    end
  endtask

  task automatic test_write;
    cyc_t e, o;
    io_write(8'hB3, 8'hFF);
    io_write(8'hB3, 8'hFF);
    io_write(8'hB3, 8'h07);
    exp_q.push_back(mk_exp(1'b1, 19'h7FFFF, 8'h5A));
    io_write(8'hBB, 8'h5A);
    vectors++;
    if (busy !== 1'b1 || mem_cs !== 1'b1 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL setup_phase: busy=%b cs=%b we=%b, required 1 1 0", busy, mem_cs, mem_we);
    end
    repeat (WC + 1) tick();
    vectors++;
    if (busy !== 1'b1 || mem_cs !== 1'b1 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_phase: busy=%b cs=%b we=%b, required 1 1 0", busy, mem_cs, mem_we);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || mem_cs !== 1'b0) begin
      miscompares++;
      $display("FAIL cycle_end: busy=%b cs=%b, required 0 0", busy, mem_cs);
    end
    wait_idle();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL write_cycle: no cycle seen, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL write_cycle: got %h, required %h", o, e);
        end
      end
    end
    vectors++;
    if (dut.addr !== 19'h0) begin
      miscompares++;
      $display("FAIL addr_wrap: addr=%h, required 0", dut.addr);
    end
  endtask

  task automatic test_read_lag;
    cyc_t e, o;
    logic [7:0] rd;
    init_pulse();
    io_write(8'hB3, 8'h00);
    io_write(8'hB3, 8'h01);
    io_write(8'hB3, 8'h00);
    exp_q.push_back(mk_exp(1'b0, 19'h00100, 8'h00));
    io_read(8'hBB, rd);
    vectors++;
    if (rd !== 8'h00) begin
      miscompares++;
      $display("FAIL read_first: got %h, required 00", rd);
    end
    wait_idle();
    exp_q.push_back(mk_exp(1'b0, 19'h00101, 8'h00));
    io_read(8'hBB, rd);
    vectors++;
    if (rd !== 8'h11) begin
      miscompares++;
      $display("FAIL read_second: got %h, required 11", rd);
    end
    wait_idle();
    vectors++;
    if (io_rdata !== 8'h22) begin
      miscompares++;
      $display("FAIL prefetch: got %h, required 22", io_rdata);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL read_cycle: no cycle seen, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL read_cycle: got %h, required %h", o, e);
        end
      end
    end
  endtask

  task automatic test_collision;
    cyc_t e, o;
    logic [AW-1:0] exp_addr;
    init_pulse();
    io_write(8'hB3, 8'h00);
    io_write(8'hB3, 8'h02);
    io_write(8'hB3, 8'h00);
`ifdef FLASH_PORT_PEND_EN
    exp_q.push_back(mk_exp(1'b1, 19'h00200, 8'hA1));
    exp_q.push_back(mk_exp(1'b1, 19'h00201, 8'hA2));
    io_write(8'hBB, 8'hA1);
    io_write(8'hBB, 8'hA2);
    io_write(8'hBB, 8'hA3);
    exp_addr = 19'h00203;
`else
    exp_q.push_back(mk_exp(1'b1, 19'h00200, 8'hA1));
    io_write(8'hBB, 8'hA1);
    io_write(8'hBB, 8'hA2);
    exp_addr = 19'h00202;
`endif
    wait_idle();
    vectors++;
    if (ovf !== 1'b1 || dut.addr !== exp_addr) begin
      miscompares++;
      $display("FAIL collision_state: ovf=%b addr=%h, required 1 %h", ovf, dut.addr, exp_addr);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL collision_cycle: no cycle seen, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL collision_cycle: got %h, required %h", o, e);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL collision_extra: %0d extra cycles, required 0", obs_q.size());
    end
  endtask

  task automatic test_abort;
    logic [AW+22:0] outs;
    init_pulse();
    io_write(8'hB3, 8'h10);
    io_write(8'hB3, 8'h00);
    io_write(8'hB3, 8'h00);
    io_write(8'hBB, 8'h99);
    io_write(8'hBB, 8'h98);
    io_write(8'hBB, 8'h97);
    vectors++;
    if (ovf !== 1'b1 || mem_we !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_abort: ovf=%b we=%b, required 1 1", ovf, mem_we);
    end
    tick();
    init = 1'b1;
    tick();
    init = 1'b0;
    vectors++;
    if (mem_we !== 1'b0 || mem_cs !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0 || dut.addr !== 19'h0) begin
      miscompares++;
      $display("FAIL init_abort: we=%b cs=%b busy=%b ovf=%b addr=%h, required 0 0 0 0 0", mem_we, mem_cs, busy, ovf, dut.addr);
    end
    tick();
    obs_q.delete();
    init = 1'b1;
    io_write(8'hBB, 8'h55);
    init = 1'b0;
    repeat (12) tick();
    vectors++;
    if (obs_q.size() != 0 || dut.addr !== 19'h0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL init_wins: cycles=%0d addr=%h busy=%b, required 0 0 0", obs_q.size(), dut.addr, busy);
    end
    io_write(8'hB3, 8'h05);
    io_write(8'hBB, 8'hC3);
    tick();
    vectors++;
    if (mem_we !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_strobe: we=%b, required 1", mem_we);
    end
    rst = 1'b1;
    #1;
    outs = {io_rdata, mem_a, mem_dout, mem_cs, mem_oe, mem_we, mem_drv, busy, ovf};
    vectors++;
    if (outs !== '0 || dut.addr !== 19'h0) begin
      miscompares++;
      $display("FAIL async_reset: outs=%h addr=%h, required 0 0", outs, dut.addr);
    end
    tick();
    rst = 1'b0;
    tick();
    obs_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem_model[i] = 8'h00;
    mem_model[256] = 8'h11;
    mem_model[257] = 8'h22;
    rst       = 1'b1;
    init      = 1'b0;
    io_wr_stb = 1'b0;
    io_rd_stb = 1'b0;
    io_addr   = 8'h00;
    io_wdata  = 8'h00;
    test_reset();
    test_addr_load();
    test_write();
    test_read_lag();
    test_collision();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/zx_flash_port.md
ZX_FLASH_PORT -- requirements
Module: zx_flash_port

Interface
REQ-001 Parameter AW, default 19: memory address width, 8..32.
REQ-002 Parameter NPH, default 3: address-load phases, SHALL equal ceil(AW/8).
REQ-003 Parameter WAIT_CYC, default 4: strobe-active cycles per memory access, 1..15.
REQ-004 Parameter ADDR_PORT, default 8'hB3: IO address of the address-load port.
REQ-005 Parameter DATA_PORT, default 8'hBB: IO address of the data port.
REQ-006 Ports SHALL be (name direction width meaning):
- clk_fpga in 1: sole clock.
- rst in 1: asynchronous, active-high reset.
- init in 1: soft-init pulse from the control register.
- io_wr_stb in 1: one-cycle pulse, ZX IO write already synchronised.
- io_rd_stb in 1: one-cycle pulse at the start of a ZX IO read.
- io_addr in 8: ZX IO address, valid with the strobes.
- io_wdata in 8: ZX write data.
- io_rdata out 8: prefetch register, sampled by the bus mux.
- mem_a out AW: memory address.
- mem_dout out 8: write data.
- mem_din in 8: read data.
- mem_cs out 1: chip select, active-high.
- mem_oe out 1: output enable.
- mem_we out 1: write enable.
- mem_drv out 1: FPGA drives the data bus.
- busy out 1: memory cycle in progress.
- ovf out 1: sticky lost-request flag.

Function
REQ-007 Write to ADDR_PORT SHALL load io_wdata into addr[8*ph +: 8] (bits at or above AW discarded), then set ph to ph+1, wrapping NPH-1 to 0.
REQ-008 Any access to DATA_PORT SHALL clear ph to 0.
REQ-009 Write to DATA_PORT SHALL request a write cycle using the current addr and io_wdata, then increment addr modulo 2^AW.
REQ-010 Read of DATA_PORT SHALL return the prefetch value present before the strobe, request a read cycle at the current addr, then increment addr modulo 2^AW. The returned data therefore lags by one read.
REQ-011 Accesses to other io_addr values SHALL be ignored.
REQ-012 FSM IDLE->SETUP (1 cycle: mem_cs=1, address stable) ->STROBE (WAIT_CYC cycles: mem_oe or mem_we =1) ->HOLD (1 cycle: strobes 0, mem_cs=1) ->IDLE.
REQ-013 busy SHALL be 1 in every state except IDLE. Total cycle length SHALL be WAIT_CYC+2 clocks after the request cycle.
REQ-014 A read cycle SHALL latch mem_din into prefetch on the last STROBE clock.
REQ-015 mem_drv SHALL be 1 from SETUP through HOLD of write cycles only.
REQ-016 mem_a and mem_dout SHALL be held constant from SETUP through HOLD.
REQ-017 A request arriving while busy SHALL be handled per REQ-022/REQ-023.
REQ-018 init SHALL, on the same clock edge:
- clear ph, addr and prefetch to 0;
- clear ovf and any pending request;
- abort the active cycle to IDLE, with strobes deasserted the next clock.
REQ-019 If init and an IO strobe occur in the same cycle, init SHALL win and the strobe SHALL be dropped.

Reset
REQ-020 rst SHALL asynchronously force FSM=IDLE, ph=0, addr=0, prefetch=0, ovf=0, pending=0. It SHALL also force all outputs to 0: io_rdata, mem_a, mem_dout, mem_cs, mem_oe, mem_we, mem_drv, busy.
REQ-021 The first cycle after rst release SHALL accept IO strobes.

Configuration
REQ-022 With FLASH_PORT_PEND_EN defined:
- a one-deep pending buffer SHALL store {type, addr, data} of a request arriving while busy, launching it on the clock after HOLD;
- a request arriving while pending is full SHALL be dropped and set ovf.
REQ-023 Without FLASH_PORT_PEND_EN, any request arriving while busy SHALL be dropped and set ovf. addr SHALL still increment, so the address sequence matches host accounting.

Structure
REQ-024 A shared package zx_flash_pkg SHALL hold:
- the FSM state enum (IDLE, SETUP, STROBE, HOLD);
- the request-type enum (REQ_RD, REQ_WR);
- the default ADDR_PORT/DATA_PORT constants.
REQ-025 The cycle sequencer SHALL be the sub-module zx_flash_seq. It takes the request handshake and emits strobes and the latch pulse. The IO decode, address/phase registers and pending buffer stay in zx_flash_port.

Verification
REQ-026 Bench SHALL cover the following directed scenarios:
- Address load: write B3 with 12,34,05 -> addr=19'h53412, ph=0. A fourth B3 write of AA -> addr[7:0]=AA.
- Write: write BB=5A at addr 7FFFF -> mem_we pulse WAIT_CYC long with mem_a=7FFFF and mem_dout=5A; addr wraps to 0.
- Read lag: memory holds 11 at 100 and 22 at 101; load 100, read BB twice -> returns 00 then 11; prefetch=22.
- Collision with macro on: three BB writes 1 clock apart -> writes 1 and 2 executed in order, third dropped, ovf=1.
- Collision with macro off: two BB writes 1 clock apart -> only the first executed, ovf=1, addr advanced by 2.
- Abort: init asserted mid-STROBE -> mem_we=0 next clock; addr=0, ovf=0, busy=0. Assert rst mid-cycle -> all outputs 0 immediately.
